// File: rtl/bp_cce_spec_tracker.sv
// Per-way-group speculative-access tracker for the CCE, swept to zero after reset.
// Define BP_CCE_SPEC_TRACKER_BYPASS_EN to forward same-cycle writes to a same-index read.
module bp_cce_spec_tracker #(
  // 0 selects e_bp_default_cfg; 1 selects a reduced 16-group config
  parameter int unsigned bp_params_p = 0,
  localparam int unsigned paddr_width_p = 40,
  localparam int unsigned cce_way_groups_p = (bp_params_p == 1) ? 16 : 64,
  localparam int unsigned bedrock_block_width_p = 512,
  // width of bp_coh_states_e
  localparam int unsigned coh_width_lp = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  output logic                     busy_o,

  input  logic                     w_v_i,
  input  logic [paddr_width_p-1:0] w_addr_i,
  input  logic                     spec_w_v_i,
  input  logic                     squash_w_v_i,
  input  logic                     fwd_mod_w_v_i,
  input  logic                     state_w_v_i,
  input  logic                     spec_i,
  input  logic                     squash_i,
  input  logic                     fwd_mod_i,
  input  logic [coh_width_lp-1:0]  state_i,

  input  logic                     r_v_i,
  input  logic [paddr_width_p-1:0] r_addr_i,
  output logic                     r_v_o,
  output logic                     spec_o,
  output logic                     squash_o,
  output logic                     fwd_mod_o,
  output logic [coh_width_lp-1:0]  state_o
);

  localparam int unsigned lg_block_size_in_bytes_lp = $clog2(bedrock_block_width_p / 8);
  localparam int unsigned lg_groups_lp = $clog2(cce_way_groups_p);
  localparam int unsigned entry_width_lp = 3 + coh_width_lp;
  localparam logic [lg_groups_lp-1:0] LastIdx = lg_groups_lp'(cce_way_groups_p - 1);

  typedef enum logic [1:0] {e_reset, e_clear, e_ready} state_e;

  state_e                    state_q;
  logic [lg_groups_lp-1:0]   clr_cnt_q;
  logic                      busy_q, r_v_q;
  logic [entry_width_lp-1:0] rd_q;
  logic [entry_width_lp-1:0] mem_q [cce_way_groups_p];

  logic [lg_groups_lp-1:0]   w_idx, r_idx;
  logic                      accept, w_en, r_en, clr_en;
  logic [entry_width_lp-1:0] w_merged, rd_old, rd_data;
  logic                      unused_addr_bits;

  assign w_idx  = w_addr_i[lg_block_size_in_bytes_lp +: lg_groups_lp];
  assign r_idx  = r_addr_i[lg_block_size_in_bytes_lp +: lg_groups_lp];
  assign unused_addr_bits = ^{w_addr_i, r_addr_i};

  assign accept = ~busy_q & ~reset_i;
  assign w_en   = w_v_i & accept;
  assign r_en   = r_v_i & accept;
  assign clr_en = (state_q == e_clear) & ~reset_i;
  assign rd_old = mem_q[r_idx];

  // Entry layout: {spec, squash, fwd_mod, state}
  always_comb begin
    w_merged = mem_q[w_idx];
    if (spec_w_v_i)    w_merged[entry_width_lp-1] = spec_i;
    if (squash_w_v_i)  w_merged[entry_width_lp-2] = squash_i;
    if (fwd_mod_w_v_i) w_merged[entry_width_lp-3] = fwd_mod_i;
    if (state_w_v_i)   w_merged[coh_width_lp-1:0] = state_i;
  end

`ifdef BP_CCE_SPEC_TRACKER_BYPASS_EN
  assign rd_data = (w_en && (w_idx == r_idx)) ? w_merged : rd_old;
`else
  assign rd_data = rd_old;
`endif

  // Storage has no reset of its own; the sweep is the only clear path.
  always_ff @(posedge clk_i) begin
    if (clr_en) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (w_en) begin
      mem_q[w_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= e_reset;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
      r_v_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      r_v_q <= r_en;
      if (r_en) rd_q <= rd_data;
      unique case (state_q)
        e_reset: begin
          state_q   <= e_clear;
          clr_cnt_q <= '0;
          busy_q    <= 1'b1;
        end
        e_clear: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LastIdx) begin
            state_q <= e_ready;
            busy_q  <= 1'b0;
          end
        end
        e_ready: busy_q <= 1'b0;
        default: begin
          state_q <= e_reset;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign r_v_o  = r_v_q;
  assign {spec_o, squash_o, fwd_mod_o, state_o} = rd_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(busy_o && (w_v_i || r_v_i)))
        else $warning("spec tracker: request dropped while busy");
    end
  end
`endif

endmodule

// File: tb/tb_bp_cce_spec_tracker.sv
// Randomised bench for bp_cce_spec_tracker against an array-based reference model.
module tb_bp_cce_spec_tracker;

  localparam int N = 64;
`ifdef BP_CCE_SPEC_TRACKER_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        busy_o;
  logic        w_v_i = 1'b0, r_v_i = 1'b0;
  logic [39:0] w_addr_i = '0, r_addr_i = '0;
  logic        spec_w_v_i = 1'b0, squash_w_v_i = 1'b0, fwd_mod_w_v_i = 1'b0, state_w_v_i = 1'b0;
  logic        spec_i = 1'b0, squash_i = 1'b0, fwd_mod_i = 1'b0;
  logic [2:0]  state_i = '0;
  logic        r_v_o, spec_o, squash_o, fwd_mod_o;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  bp_cce_spec_tracker dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .busy_o       (busy_o),
    .w_v_i        (w_v_i),
    .w_addr_i     (w_addr_i),
    .spec_w_v_i   (spec_w_v_i),
    .squash_w_v_i (squash_w_v_i),
    .fwd_mod_w_v_i(fwd_mod_w_v_i),
    .state_w_v_i  (state_w_v_i),
    .spec_i       (spec_i),
    .squash_i     (squash_i),
    .fwd_mod_i    (fwd_mod_i),
    .state_i      (state_i),
    .r_v_i        (r_v_i),
    .r_addr_i     (r_addr_i),
    .r_v_o        (r_v_o),
    .spec_o       (spec_o),
    .squash_o     (squash_o),
    .fwd_mod_o    (fwd_mod_o),
    .state_o      (state_o)
  );

  int total = 0;
  int bad = 0;

  // Reference model: entry = {spec, squash, fwd_mod, state[2:0]}
  logic [5:0] model [N];
  logic       exp_busy = 1'b1;
  logic       exp_rv = 1'b0;
  logic [5:0] exp_f = '0;
  int         rel = 0;
  bit         chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [5:0] merge(input logic [5:0] old, input logic [3:0] en,
                                       input logic [5:0] d);
    logic [5:0] r;
    r = old;
    if (en[3]) r[5] = d[5];
    if (en[2]) r[4] = d[4];
    if (en[1]) r[3] = d[3];
    if (en[0]) r[2:0] = d[2:0];
    return r;
  endfunction

  function automatic logic [39:0] addr(input logic [5:0] idx);
    logic [39:0] a;
    a = {8'($urandom), $urandom};
    a[11:6] = idx;
    return a;
  endfunction

  function automatic logic [5:0] fields();
    return {spec_o, squash_o, fwd_mod_o, state_o};
  endfunction

  task automatic tick(input bit rst, input bit wv, input int wi, input logic [3:0] en,
                      input logic [5:0] wd, input bit rv, input int ri);
    logic [5:0] res, nw;
    bit acc;
    @(negedge clk);
    reset_i = rst;
    w_v_i = wv;
    w_addr_i = addr(wi[5:0]);
    {spec_w_v_i, squash_w_v_i, fwd_mod_w_v_i, state_w_v_i} = en;
    {spec_i, squash_i, fwd_mod_i, state_i} = wd;
    r_v_i = rv;
    r_addr_i = addr(ri[5:0]);
    if (rst) begin
      rel = 0;
      exp_busy = 1'b1;
      exp_rv = 1'b0;
      exp_f = '0;
    end else begin
      acc = !exp_busy;
      res = model[ri];
      if (acc && wv) begin
        nw = merge(model[wi], en, wd);
        if (Byp && wi == ri) res = nw;
        model[wi] = nw;
      end
      exp_rv = acc && rv;
      if (exp_rv) exp_f = res;
      if (rel < 1000) rel++;
      if (rel == N + 1) begin
        for (int i = 0; i < N; i++) model[i] = '0;
      end
      exp_busy = (rel <= N);
    end
    chk_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input bit rst);
    tick(rst, 1'b0, 0, 4'h0, 6'h0, 1'b0, 0);
  endtask

  // Counts busy cycles from the first reset-low edge; a dropped request goes in at drop_k.
  task automatic count_sweep(input string name, input int drop_k);
    int  n;
    bit  done;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      if (k == drop_k) begin
        tick(1'b0, 1'b1, 3, 4'hf, 6'h3f, 1'b1, 3);
        chk({name, "_drop_rv"}, r_v_o, 0);
      end else begin
        idle(1'b0);
      end
      if (busy_o === 1'b1) n++;
      else done = 1'b1;
    end
    chk({name, "_done"}, done, 1);
    chk({name, "_len"}, n, N);
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("busy_o", busy_o, exp_busy);
      chk("r_v_o", r_v_o, exp_rv);
      chk("fields", fields(), exp_f);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int wi, ri;
    for (int i = 0; i < N; i++) model[i] = '0;

    repeat (3) idle(1'b1);
    chk("rst_busy", busy_o, 1);
    chk("rst_rv", r_v_o, 0);
    chk("rst_fields", fields(), 6'h00);

    count_sweep("sweep1", 5);

    for (int i = 0; i < N; i++) begin
      tick(1'b0, 1'b0, 0, 4'h0, 6'h0, 1'b1, i);
      chk("clr_rv", r_v_o, 1);
      chk("clr_data", fields(), 6'h00);
    end

    // spec + state(M) only, then read back
    tick(1'b0, 1'b1, 5, 4'b1001, 6'b100111, 1'b0, 0);
    tick(1'b0, 1'b0, 0, 4'h0, 6'h0, 1'b1, 5);
    chk("w5_rv", r_v_o, 1);
    chk("w5_spec", spec_o, 1);
    chk("w5_state", state_o, 3'd7);
    chk("w5_squash", squash_o, 0);
    chk("w5_fwd", fwd_mod_o, 0);

    // same-cycle squash write and read of index 5
    tick(1'b0, 1'b1, 5, 4'b0100, 6'b010000, 1'b1, 5);
    chk("rdw_squash", squash_o, Byp ? 1 : 0);
    chk("rdw_spec", spec_o, 1);
    idle(1'b0);
    chk("hold_squash", squash_o, Byp ? 1 : 0);
    tick(1'b0, 1'b0, 0, 4'h0, 6'h0, 1'b1, 5);
    chk("after_squash", squash_o, 1);

    // different-index write/read in one cycle
    tick(1'b0, 1'b1, 9, 4'hf, 6'b001010, 1'b0, 0);
    tick(1'b0, 1'b1, 7, 4'hf, 6'b110011, 1'b1, 9);
    chk("r9_old", fields(), 6'b001010);
    tick(1'b0, 1'b0, 0, 4'h0, 6'h0, 1'b1, 7);
    chk("r7_new", fields(), 6'b110011);

    // enables all low must change nothing
    tick(1'b0, 1'b1, 7, 4'h0, 6'b001100, 1'b0, 0);
    tick(1'b0, 1'b0, 0, 4'h0, 6'h0, 1'b1, 7);
    chk("noen_r7", fields(), 6'b110011);

    for (int k = 0; k < 500; k++) begin
      wi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : int'($urandom_range(0, 7));
      ri = ($urandom_range(0, 1) == 0) ? wi : int'($urandom_range(0, 7));
      tick(1'b0, 1'($urandom), wi, 4'($urandom), 6'($urandom), 1'($urandom), ri);
    end

    // reset mid-sweep restarts the full sweep
    idle(1'b1);
    idle(1'b0);
    repeat (30) idle(1'b0);
    idle(1'b1);
    count_sweep("sweep2", 10);
    tick(1'b0, 1'b0, 0, 4'h0, 6'h0, 1'b1, 5);
    chk("post_sweep_r5", fields(), 6'h00);

    for (int k = 0; k < 100; k++) begin
      wi = int'($urandom_range(0, 7));
      ri = ($urandom_range(0, 1) == 0) ? wi : int'($urandom_range(0, 7));
      tick(1'b0, 1'($urandom), wi, 4'($urandom), 6'($urandom), 1'($urandom), ri);
    end

    idle(1'b0);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
